// File: rtl/siso_sched.sv
// Half-iteration scheduler for a turbo SISO core: streams LLR/apriori buffer
// reads for each half-iteration and sequences iterations until done or converged.
module siso_sched #(
    parameter int MIN_BLK = 40,
    parameter int MAX_BLK = 6144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] blklen,
    input  logic [3:0]  n_iter,
    input  logic        early_stop,
    input  logic        siso_done,
    output logic        llr_rd,
    output logic [13:0] llr_addr,
    output logic        apr_rd,
    output logic [12:0] apr_addr,
    output logic        bank,
    output logic        apr_zero,
    output logic        siso_valid_in,
    output logic        siso_valid_apriori,
    output logic        siso_first,
    output logic [12:0] siso_blklen,
    output logic [4:0]  half_idx,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, FEED, WAIT, NEXT, FIN} state_t;

    state_t      state, state_nx;
    logic [12:0] k_q;
    logic [3:0]  n_q;
    logic [13:0] c_q;
    logic [4:0]  half_q;
    logic        bank_q;
    logic        vin_q, vap_q, first_q, err_q;
    logic        legal, feed, stop_now;
    logic [13:0] c_last;
    logic [4:0]  half_last;

    assign legal     = (32'(blklen) >= MIN_BLK) && (32'(blklen) <= MAX_BLK);
    assign feed      = (state == FEED);
    assign c_last    = {k_q, 1'b0} - 14'd1;
    assign half_last = {n_q, 1'b0} - 5'd1;
    // Convergence is only trusted after a full iteration, i.e. on odd halves.
    assign stop_now  = (early_stop && half_q[0]) || (half_q == half_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && legal) state_nx = FEED;
            FEED: if (c_q == c_last) state_nx = WAIT;
            WAIT: if (siso_done) state_nx = stop_now ? FIN : NEXT;
            NEXT: state_nx = FEED;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q     <= '0;
            n_q     <= '0;
            c_q     <= '0;
            half_q  <= '0;
            bank_q  <= 1'b0;
            vin_q   <= 1'b0;
            vap_q   <= 1'b0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Buffer reads return one cycle later, so SISO strobes lag the reads.
            vin_q   <= feed;
            vap_q   <= feed && !c_q[0];
            first_q <= feed && (c_q == 14'd0);
            err_q   <= (state == IDLE) && start && !legal;
            case (state)
                IDLE: if (start && legal) begin
                    k_q    <= blklen;
                    n_q    <= (n_iter == 4'd0) ? 4'd1 : n_iter;
                    half_q <= '0;
                    bank_q <= 1'b0;
                    c_q    <= '0;
                end
                FEED: if (c_q != c_last) c_q <= c_q + 14'd1;
                NEXT: begin
                    if (half_q != 5'd29) half_q <= half_q + 5'd1;
                    bank_q <= ~bank_q;
                    c_q    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy               = (state != IDLE);
    assign done               = (state == FIN);
    assign err                = err_q;
    assign llr_rd             = feed;
    assign llr_addr           = c_q;
    assign apr_rd             = feed && !c_q[0] && (half_q != 5'd0);
    assign apr_addr           = c_q[13:1];
    assign bank               = bank_q;
    assign apr_zero           = busy && (half_q == 5'd0);
    assign siso_valid_in      = vin_q;
    assign siso_valid_apriori = vap_q;
    assign siso_first         = first_q;
    assign siso_blklen        = busy ? k_q : 13'd0;
    assign half_idx           = half_q;

endmodule

// File: tb/tb_siso_sched.sv
// Bench for siso_sched: cycle model of the schedule rules compared every cycle,
// plus hand-computed per-block totals for the directed scenarios.
module tb_siso_sched;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, early_stop = 1'b0, siso_done = 1'b0;
    logic [12:0] blklen = '0;
    logic [3:0]  n_iter = '0;
    logic        llr_rd, apr_rd, bank, apr_zero, siso_valid_in, siso_valid_apriori, siso_first;
    logic        busy, done, err;
    logic [13:0] llr_addr;
    logic [12:0] apr_addr, siso_blklen;
    logic [4:0]  half_idx;

    siso_sched dut (
        .clk(clk), .rst(rst), .start(start), .blklen(blklen), .n_iter(n_iter),
        .early_stop(early_stop), .siso_done(siso_done),
        .llr_rd(llr_rd), .llr_addr(llr_addr), .apr_rd(apr_rd), .apr_addr(apr_addr),
        .bank(bank), .apr_zero(apr_zero), .siso_valid_in(siso_valid_in),
        .siso_valid_apriori(siso_valid_apriori), .siso_first(siso_first),
        .siso_blklen(siso_blklen), .half_idx(half_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 feeding, 2 waiting for SISO, 3 advancing, 4 finishing
    int m_st = 0, m_c = 0, m_half = 0, m_K = 0, m_N = 0;
    bit m_bank = 0, m_err = 0, m_vin = 0, m_vap = 0, m_first = 0;
    int llr_cnt[32], apr_cnt[32], bank1_cnt[32];
    int done_cnt = 0, err_cnt = 0, first_cnt = 0, lag_err = 0;
    bit prev_llr = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_st = 0; m_c = 0; m_half = 0; m_K = 0; m_N = 0;
            m_bank = 0; m_err = 0; m_vin = 0; m_vap = 0; m_first = 0;
        end else begin
            m_vin   = (m_st == 1);
            m_vap   = (m_st == 1) && (m_c % 2 == 0);
            m_first = (m_st == 1) && (m_c == 0);
            m_err   = (m_st == 0) && start && (int'(blklen) < 40 || int'(blklen) > 6144);
            case (m_st)
                0: if (start && int'(blklen) >= 40 && int'(blklen) <= 6144) begin
                    m_K = int'(blklen); m_N = (n_iter == 0) ? 1 : int'(n_iter);
                    m_half = 0; m_bank = 0; m_c = 0; m_st = 1;
                end
                1: if (m_c == 2 * m_K - 1) m_st = 2; else m_c++;
                2: if (siso_done)
                    m_st = ((early_stop && m_half % 2 == 1) || m_half == 2 * m_N - 1) ? 4 : 3;
                3: begin
                    if (m_half < 29) m_half++;
                    m_bank = !m_bank; m_c = 0; m_st = 1;
                end
                default: m_st = 0;
            endcase
        end
        #1;
        chk("busy", busy, m_st != 0);
        chk("done", done, m_st == 4);
        chk("err", err, m_err);
        chk("llr_rd", llr_rd, m_st == 1);
        chk("apr_rd", apr_rd, (m_st == 1) && (m_c % 2 == 0) && (m_half > 0));
        chk("siso_valid_in", siso_valid_in, m_vin);
        chk("siso_valid_apriori", siso_valid_apriori, m_vap);
        chk("siso_first", siso_first, m_first);
        if (m_st == 1) chk("llr_addr", llr_addr, m_c);
        if (m_st == 1 && m_c % 2 == 0 && m_half > 0) chk("apr_addr", apr_addr, m_c / 2);
        if (m_st != 0) begin
            chk("half_idx", half_idx, m_half);
            chk("bank", bank, m_bank);
            chk("apr_zero", apr_zero, m_half == 0);
            chk("siso_blklen", siso_blklen, m_K);
        end
        if (llr_rd) llr_cnt[half_idx]++;
        if (apr_rd) apr_cnt[half_idx]++;
        if (llr_rd && bank) bank1_cnt[half_idx]++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (siso_first) first_cnt++;
        if (siso_valid_in != prev_llr) lag_err++;
        prev_llr = llr_rd;
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 32; i++) begin llr_cnt[i] = 0; apr_cnt[i] = 0; bank1_cnt[i] = 0; end
        done_cnt = 0; err_cnt = 0; first_cnt = 0; lag_err = 0;
    endtask

    task automatic pulse_start(int k, int n);
        start = 1'b1; blklen = 13'(k); n_iter = 4'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_model(int st, int budget, string name);
        int i = 0;
        while (m_st != st && i < budget) begin @(negedge clk); i++; end
        chk(name, m_st, st);
    endtask

    task automatic finish_block(int k, int es_mask);
        for (int h = 0; h < 32; h++) begin
            wait_model(2, 2 * k + 20, "reach_wait");
            if (m_st != 2) break;
            cyc(4);
            siso_done = 1'b1; early_stop = es_mask[h];
            @(negedge clk);
            siso_done = 1'b0; early_stop = 1'b0;
            if (m_st == 4) break;
        end
        cyc(2);
    endtask

    initial begin
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_llr_rd", llr_rd, 0);
        chk("rst_siso_blklen", siso_blklen, 0);
        chk("rst_half_idx", half_idx, 0);
        chk("rst_bank", bank, 0);
        rst = 1'b1;
        cyc(2);

        // Length bounds
        clr_cnt();
        pulse_start(39, 1);
        chk("err_39", err, 1);
        chk("busy_39", busy, 0);
        cyc(1);
        pulse_start(6145, 1);
        chk("err_6145", err, 1);
        chk("busy_6145", busy, 0);
        cyc(1);
        pulse_start(6144, 1);
        chk("busy_6144", busy, 1);
        chk("blklen_6144", siso_blklen, 6144);
        cyc(20);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        cyc(2);
        rst = 1'b1;
        cyc(2);
        chk("bounds_err_cnt", err_cnt, 2);
        chk("bounds_done_cnt", done_cnt, 0);

        // K=512, single iteration
        clr_cnt();
        pulse_start(512, 1);
        finish_block(512, 0);
        chk("k512_llr_h0", llr_cnt[0], 1024);
        chk("k512_llr_h1", llr_cnt[1], 1024);
        chk("k512_apr_h0", apr_cnt[0], 0);
        chk("k512_apr_h1", apr_cnt[1], 512);
        chk("k512_bank_h0", bank1_cnt[0], 0);
        chk("k512_bank_h1", bank1_cnt[1], 1024);
        chk("k512_done", done_cnt, 1);
        chk("k512_halves", first_cnt, 2);

        // K=40 with n_iter=0
        clr_cnt();
        pulse_start(40, 0);
        finish_block(40, 0);
        chk("k40_halves", first_cnt, 2);
        chk("k40_llr_h0", llr_cnt[0], 80);
        chk("k40_llr_h1", llr_cnt[1], 80);
        chk("k40_llr_h2", llr_cnt[2], 0);
        chk("k40_done", done_cnt, 1);
        chk("k40_lag", lag_err, 0);

        // Early stop: ignored on even half 2, honoured on odd half 3
        clr_cnt();
        pulse_start(512, 4);
        finish_block(512, 32'b1100);
        chk("es_halves", first_cnt, 4);
        chk("es_llr_h3", llr_cnt[3], 1024);
        chk("es_llr_h4", llr_cnt[4], 0);
        chk("es_done", done_cnt, 1);

        // Reset mid-feed of half 1, then a clean K=64 block
        clr_cnt();
        pulse_start(512, 1);
        wait_model(2, 1100, "rst_reach_wait");
        cyc(4);
        siso_done = 1'b1;
        @(negedge clk);
        siso_done = 1'b0;
        begin
            int i = 0;
            while (!(m_st == 1 && m_half == 1 && m_c == 300) && i < 2000) begin @(negedge clk); i++; end
        end
        chk("rst_at_c300", m_c, 300);
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_llr_rd", llr_rd, 0);
        chk("arst_apr_rd", apr_rd, 0);
        chk("arst_valid_in", siso_valid_in, 0);
        chk("arst_valid_apr", siso_valid_apriori, 0);
        chk("arst_bank", bank, 0);
        chk("arst_half_idx", half_idx, 0);
        chk("arst_blklen", siso_blklen, 0);
        chk("arst_llr_addr", llr_addr, 0);
        cyc(2);
        rst = 1'b1;
        cyc(2);
        chk("arst_no_done", done_cnt, 0);
        clr_cnt();
        pulse_start(64, 2);
        finish_block(64, 0);
        chk("k64_halves", first_cnt, 4);
        chk("k64_llr_h3", llr_cnt[3], 128);
        chk("k64_apr_h2", apr_cnt[2], 64);
        chk("k64_done", done_cnt, 1);

        // Stray siso_done in FEED and start while busy
        clr_cnt();
        pulse_start(40, 2);
        cyc(10);
        siso_done = 1'b1;
        @(negedge clk);
        siso_done = 1'b0;
        pulse_start(100, 1);
        finish_block(40, 0);
        chk("ign_halves", first_cnt, 4);
        chk("ign_llr_h0", llr_cnt[0], 80);
        chk("ign_llr_h3", llr_cnt[3], 80);
        chk("ign_done", done_cnt, 1);
        chk("ign_err", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
